// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// fetch granularity and the default post-reset fetch address.
package fetch_unit_pkg;

    // Fetch FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

    // Bytes per instruction word; the PC advances by this much per fetch.
    localparam int unsigned INSTR_BYTES = 4;

    // Default first fetch address after reset.
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE -> REQ -> VALID loop issuing one word fetch
// per trip, holding the fetched word while the consumer stalls, and
// redirecting on a branch strobe.
//
// Memory handshake: imem_req is high only in REQ, with imem_addr stable, until
// imem_ack is seen high on a rising edge; imem_rdata is taken in that same
// cycle. An ack arriving in any other state, or together with br_valid or
// rst, is ignored.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [31:0]      br_target,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc_next,
    output logic [CNT_W-1:0] fetch_count,
    output fetch_state_t     state_dbg
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    fetch_state_t state;
    logic [31:0]  pc;

    // The PC register is the only address source: both the memory address
    // and the downstream PC input are direct copies of it.
    assign imem_addr = pc;
    assign pc_next   = pc;
    assign state_dbg = state;

    // Fetch FSM with registered outputs; reset beats branch, branch beats
    // stall and ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= RESET_ADDR;
            imem_req    <= 1'b0;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else if (br_valid) begin
            // Word-align the target; any coincident ack is dropped.
            pc          <= br_target & ~32'h3;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            state       <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    imem_req <= 1'b1;
                    state    <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        pc          <= pc + 32'(INSTR_BYTES);
                        if (fetch_count != CNT_MAX) begin
                            fetch_count <= fetch_count + CNT_W'(1);
                        end
                        imem_req    <= 1'b0;
                        state       <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter CNT_W, default 16, SHALL be the width of fetch_count.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 stall  input  1  SHALL be the downstream hold request; while high, the presented instruction is held.
REQ-006 br_valid  input  1  SHALL be a one-cycle branch redirect strobe.
REQ-007 br_target  input  32  SHALL be the branch target address, sampled when br_valid=1.
REQ-008 imem_req  output  1  SHALL be the instruction memory request.
REQ-009 imem_addr  output  32  SHALL be the word address of the request, valid while imem_req=1.
REQ-010 imem_ack  input  1  SHALL be memory completion; imem_rdata is valid in the same cycle.
REQ-011 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-012 instr  output  32  SHALL be the fetched instruction.
REQ-013 instr_valid  output  1  SHALL mark instr as valid.
REQ-014 pc_next  output  32  SHALL be the next fetch address, driven to the Di input of the downstream PC register.
REQ-015 fetch_count  output  CNT_W  SHALL count accepted fetches.

Function
REQ-016 FSM states: IDLE, REQ, VALID, encoded in 2 bits.
REQ-017 IDLE SHALL go to REQ unconditionally on the next cycle, with imem_req=0.
REQ-018 In REQ, imem_req=1 and imem_addr=pc SHALL be held stable until imem_ack=1.
REQ-019 On imem_ack in REQ:
- instr<=imem_rdata
- instr_valid<=1
- pc<=pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC+4 = 0)
- fetch_count<=fetch_count+1, saturating at all-ones
- next state VALID
REQ-020 In VALID with stall=1, instr, instr_valid and pc SHALL hold and the state SHALL remain VALID.
REQ-021 In VALID with stall=0:
- instr_valid SHALL clear on the next edge
- next state REQ
REQ-022 Each fetched word SHALL therefore be presented for at least one cycle, with a minimum fetch period of 2 cycles at zero-wait memory.
REQ-023 br_valid=1 in any state SHALL have priority over stall and imem_ack:
- pc<=br_target with bits [1:0] forced to 0
- instr_valid<=0
- next state IDLE
REQ-024 An imem_ack coincident with br_valid SHALL be discarded: instr and fetch_count unchanged.
REQ-025 pc_next SHALL equal the internal pc register at all times; it is registered, not combinational.
REQ-026 imem_ack outside REQ SHALL be ignored.
REQ-027 imem_req SHALL be a registered state decode with no glitches.

Reset
REQ-028 rst=1 SHALL force, on the next edge:
- state=IDLE
- pc=pc_next=RESET_ADDR
- imem_req=0
- instr=0
- instr_valid=0
- fetch_count=0
REQ-029 rst SHALL have priority over br_valid, stall and imem_ack, including a reset asserted mid-REQ; an outstanding ack is dropped.

Structure
REQ-030 A shared package SHALL hold:
- the FSM state typedef
- the constant INSTR_BYTES=4
- the default RESET_ADDR
REQ-031 There SHALL be no sub-modules; the PC increment and saturating counter stay inline.

Verification
REQ-032 Reset, then zero-wait ack with rdata 32'hE3A0_0001 -> imem_req rises at cycle 2 with addr 0; instr=E3A00001 valid; pc_next=4; fetch_count=1.
REQ-033 Ack delayed 3 cycles -> imem_addr stays 0 and imem_req stays high for 3 cycles; one fetch counted.
REQ-034 stall=1 for 5 cycles while VALID -> instr and instr_valid unchanged, imem_req=0, pc_next=4 throughout.
REQ-035 br_valid with br_target=32'h0000_0107, coincident with an ack -> ack discarded; next request addr=32'h0000_0104; fetch_count unchanged.
REQ-036 RESET_ADDR=32'hFFFF_FFFC, one fetch -> pc_next=0; with CNT_W=2, four fetches -> fetch_count stays 3.
REQ-037 rst asserted mid-REQ -> all outputs at reset values next cycle; ack in that cycle ignored.
